// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON output serializer slice:
// the 5x64 state word, output-mode encodings, and per-capture word counts.
package ascon_pack;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    // Encoding of mode_i.
    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_DATA  = 2'b01;
    localparam logic [1:0] MODE_FINAL = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    // Number of 32-bit words emitted per capture.
    localparam logic [2:0] WORDS_DATA = 3'd2;
    localparam logic [2:0] WORDS_TAG  = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    // Counter value at which the final word of a capture is on the bus.
    function automatic logic [1:0] last_word_idx(input logic [2:0] words);
        logic [2:0] idx;
        idx = words - 3'd1;
        return idx[1:0];
    endfunction

endpackage

// File: rtl/ascon_output_serializer_if.sv
// Valid/ready word stream leaving the serializer.
interface ascon_output_serializer_if;

    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic        out_kind_o;

    modport master (
        output out_data_o,
        output out_valid_o,
        input  out_ready_i,
        output out_last_o,
        output out_kind_o
    );

    modport slave (
        input  out_data_o,
        input  out_valid_o,
        output out_ready_i,
        input  out_last_o,
        input  out_kind_o
    );

endinterface

// File: rtl/ascon_output_serializer_xor_down.sv
// xor_down: final key/data xoring applied to the permuted state.
// Produces the ciphertext block C, the tag T and the updated state for the
// selected mode; purely combinational.
module xor_down
    import ascon_pack::*;
(
    input  type_state    state,
    input  logic [127:0] key,
    input  logic [63:0]  data,
    input  logic [1:0]   mode,
    output type_state    state_mod,
    output logic [63:0]  c,
    output logic [127:0] t
);

    assign c = state.x0 ^ data;
    assign t = {state.x3 ^ key[127:64], state.x4 ^ key[63:0]};

    // Select the state update for the active mode.
    always_comb begin
        // NOTE: state_mod is assigned its default before any condition so every path drives it and no latch is inferred.
        state_mod = state;
        if (mode == MODE_DATA) begin
            state_mod.x0 = c;
        end else if (mode == MODE_FINAL) begin
            state_mod.x3 = t[127:64];
            state_mod.x4 = t[63:0];
        end
    end

endmodule

// File: rtl/ascon_output_serializer.sv
// ascon_output_serializer: captures C (mode 01) or T (mode 10) from the
// permuted state and emits it MSB first as 32-bit words on a valid/ready
// stream. Optional feature macro: ASCON_TAG_CHECK_EN adds expected_tag_i and
// a one-cycle tag_ok_o pulse after the last tag word is accepted.
module ascon_output_serializer
    import ascon_pack::*;
(
    input  logic         clock_i,
    input  logic         reset_i,
    input  type_state    state_i,
    input  logic         state_valid_i,
    input  logic [1:0]   mode_i,
    input  logic [127:0] key_i,
    input  logic [63:0]  data_i,
    output logic         busy_o,
    output type_state    state_o,
`ifdef ASCON_TAG_CHECK_EN
    input  logic [127:0] expected_tag_i,
    output logic         tag_ok_o,
`endif
    ascon_output_serializer_if.master out_if
);

    ser_state_t   fsm_q, fsm_d;
    logic [1:0]   cnt_q;
    logic [1:0]   last_idx_q;
    logic         kind_q;
    logic [127:0] shreg_q;
    type_state    state_q;

    type_state    state_mod;
    logic [63:0]  c_word;
    logic [127:0] t_word;

    logic capture;
    logic xfer;
    logic last_xfer;
    logic sending;

    xor_down u_xor_down (
        .state     (state_i),
        .key       (key_i),
        .data      (data_i),
        .mode      (mode_i),
        .state_mod (state_mod),
        .c         (c_word),
        .t         (t_word)
    );

    assign sending   = (fsm_q == S_SEND);
    assign capture   = (fsm_q == S_IDLE) && state_valid_i &&
                       ((mode_i == MODE_DATA) || (mode_i == MODE_FINAL));
    assign xfer      = sending && out_if.out_ready_i;
    assign last_xfer = xfer && (cnt_q == last_idx_q);

    // FSM state register.
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state: capture only from IDLE, leave SEND on the last transfer.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: if (capture)   fsm_d = S_SEND;
            S_SEND: if (last_xfer) fsm_d = S_IDLE;
            default:               fsm_d = S_IDLE;
        endcase
    end

    // Capture registers, output shift register and word counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            // NOTE: the wide state and shift registers are reset explicitly because state_o and out_data_o must read zero after reset.
            state_q    <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
            kind_q     <= 1'b0;
        end else if (capture) begin
            state_q <= state_mod;
            cnt_q   <= '0;
            if (mode_i == MODE_DATA) begin
                // C is left-aligned so both modes shift out of bits [127:96].
                shreg_q    <= {c_word, 64'd0};
                last_idx_q <= last_word_idx(WORDS_DATA);
                kind_q     <= 1'b0;
            end else begin
                shreg_q    <= t_word;
                last_idx_q <= last_word_idx(WORDS_TAG);
                kind_q     <= 1'b1;
            end
        end else if (xfer) begin
            shreg_q <= {shreg_q[95:0], 32'd0};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

`ifdef ASCON_TAG_CHECK_EN
    logic match_q;
    logic tag_ok_q;

    // Compare T against the expected tag at capture; pulse after the last tag word.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            match_q  <= 1'b0;
            tag_ok_q <= 1'b0;
        end else begin
            if (capture) begin
                match_q <= (mode_i == MODE_FINAL) && (t_word == expected_tag_i);
            end
            tag_ok_q <= last_xfer && kind_q && match_q;
        end
    end

    assign tag_ok_o = tag_ok_q;
`endif

    assign busy_o             = sending;
    assign state_o            = state_q;
    assign out_if.out_valid_o = sending;
    assign out_if.out_data_o  = shreg_q[127:96];
    assign out_if.out_last_o  = sending && (cnt_q == last_idx_q);
    assign out_if.out_kind_o  = kind_q;

endmodule

// File: tb/tb_ascon_output_serializer.sv
// Directed self-checking bench for ascon_output_serializer.
// Build with +define+ASCON_TAG_CHECK_EN to also exercise the tag check.
module tb_ascon_output_serializer;
    import ascon_pack::*;

    logic         clock_i;
    logic         reset_i;
    type_state    state_i;
    logic         state_valid_i;
    logic [1:0]   mode_i;
    logic [127:0] key_i;
    logic [63:0]  data_i;
    logic         busy_o;
    type_state    state_o;
`ifdef ASCON_TAG_CHECK_EN
    logic [127:0] expected_tag_i;
    logic         tag_ok_o;
`endif

    int checks;
    int failures;

    ascon_output_serializer_if out_if ();

    ascon_output_serializer dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .state_i       (state_i),
        .state_valid_i (state_valid_i),
        .mode_i        (mode_i),
        .key_i         (key_i),
        .data_i        (data_i),
        .busy_o        (busy_o),
        .state_o       (state_o),
`ifdef ASCON_TAG_CHECK_EN
        .expected_tag_i(expected_tag_i),
        .tag_ok_o      (tag_ok_o),
`endif
        .out_if        (out_if.master)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // Check one visible output word.
    task automatic check_word(input string tag, input logic [31:0] d, input logic last, input logic kind);
        check({tag, "_valid"}, 128'(out_if.out_valid_o), 128'(1'b1));
        check({tag, "_busy"},  128'(busy_o),             128'(1'b1));
        check({tag, "_data"},  128'(out_if.out_data_o),  128'(d));
        check({tag, "_last"},  128'(out_if.out_last_o),  128'(last));
        check({tag, "_kind"},  128'(out_if.out_kind_o),  128'(kind));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 128'(out_if.out_valid_o), 128'(1'b0));
        check({tag, "_busy"},  128'(busy_o),             128'(1'b0));
    endtask

    type_state st_a;
    type_state st_b;

    initial begin
        checks          = 0;
        failures        = 0;
        reset_i         = 1'b1;
        state_valid_i   = 1'b0;
        mode_i          = MODE_NONE;
        key_i           = '0;
        data_i          = '0;
        state_i         = '0;
        out_if.out_ready_i = 1'b1;
`ifdef ASCON_TAG_CHECK_EN
        expected_tag_i  = '0;
`endif
        step();
        step();

        // Reset values.
        check_idle("rst");
        check("rst_data",  128'(out_if.out_data_o), 128'd0);
        check("rst_last",  128'(out_if.out_last_o), 128'd0);
        check("rst_kind",  128'(out_if.out_kind_o), 128'd0);
        check("rst_state", 128'(state_o.x0 | state_o.x1 | state_o.x2 | state_o.x3 | state_o.x4), 128'd0);
`ifdef ASCON_TAG_CHECK_EN
        check("rst_tag_ok", 128'(tag_ok_o), 128'd0);
`endif
        reset_i = 1'b0;
        step();

        // Mode 01: C = 0123456789ABCDEF ^ FFFFFFFF00000000 = FEDCBA9889ABCDEF.
        st_a = '{x0: 64'h0123456789ABCDEF, x1: 64'hA1A1A1A1A1A1A1A1, x2: 64'hB2B2B2B2B2B2B2B2,
                 x3: 64'hC3C3C3C3C3C3C3C3, x4: 64'hD4D4D4D4D4D4D4D4};
        state_i       = st_a;
        data_i        = 64'hFFFFFFFF00000000;
        mode_i        = MODE_DATA;
        state_valid_i = 1'b1;
        step();
        // Captured; a mode-10 request during SEND must be ignored.
        mode_i  = MODE_FINAL;
        state_i = '{x0: 64'h0, x1: 64'h0, x2: 64'h0, x3: 64'h5555555555555555, x4: 64'h6666666666666666};
        check_word("m1_w0", 32'hFEDCBA98, 1'b0, 1'b0);
        check("m1_x0", 128'(state_o.x0), 128'(64'hFEDCBA9889ABCDEF));
        check("m1_x1", 128'(state_o.x1), 128'(64'hA1A1A1A1A1A1A1A1));
        check("m1_x4", 128'(state_o.x4), 128'(64'hD4D4D4D4D4D4D4D4));
        step();
        // state_valid_i is still high in the last-transfer cycle.
        check_word("m1_w1", 32'h89ABCDEF, 1'b1, 1'b0);
        step();
        state_valid_i = 1'b0;
        check_idle("m1_done");
        check("m1_hold_x0", 128'(state_o.x0), 128'(64'hFEDCBA9889ABCDEF));
        check("m1_hold_x3", 128'(state_o.x3), 128'(64'hC3C3C3C3C3C3C3C3));
        step();
        check_idle("m1_idle2");

        // Modes 11 and 00 in IDLE: no capture.
        mode_i        = MODE_RSVD;
        state_valid_i = 1'b1;
        step();
        check_idle("m3");
        check("m3_x0", 128'(state_o.x0), 128'(64'hFEDCBA9889ABCDEF));
        mode_i = MODE_NONE;
        step();
        check_idle("m0");
        check("m0_x3", 128'(state_o.x3), 128'(64'hC3C3C3C3C3C3C3C3));
        state_valid_i = 1'b0;

        // Mode 10: T = {1111..^1111.., 2222..^0} = {0, 2222222222222222}.
        st_b = '{x0: 64'h0F0F0F0F0F0F0F0F, x1: 64'h0, x2: 64'h0,
                 x3: 64'h1111111111111111, x4: 64'h2222222222222222};
        state_i = st_b;
        key_i   = 128'h1111111111111111_0000000000000000;
        mode_i  = MODE_FINAL;
        state_valid_i = 1'b1;
`ifdef ASCON_TAG_CHECK_EN
        expected_tag_i = 128'h0000000000000000_2222222222222222;
`endif
        step();
        state_valid_i = 1'b0;
        check_word("m2_w0", 32'h00000000, 1'b0, 1'b1);
        check("m2_x3", 128'(state_o.x3), 128'(64'h0));
        check("m2_x4", 128'(state_o.x4), 128'(64'h2222222222222222));
        check("m2_x0", 128'(state_o.x0), 128'(64'h0F0F0F0F0F0F0F0F));
        step();
        check_word("m2_w1", 32'h00000000, 1'b0, 1'b1);
        step();
        check_word("m2_w2", 32'h22222222, 1'b0, 1'b1);
        step();
        check_word("m2_w3", 32'h22222222, 1'b1, 1'b1);
`ifdef ASCON_TAG_CHECK_EN
        check("m2_tag_ok_early", 128'(tag_ok_o), 128'd0);
`endif
        step();
        check_idle("m2_done");
`ifdef ASCON_TAG_CHECK_EN
        check("m2_tag_ok", 128'(tag_ok_o), 128'd1);
`endif
        step();
`ifdef ASCON_TAG_CHECK_EN
        check("m2_tag_ok_pulse", 128'(tag_ok_o), 128'd0);
`endif

        // Mode 01 with out_ready_i low for the first 3 valid cycles.
        state_i.x0    = 64'h00000000FFFFFFFF;
        data_i        = 64'h1234567812345678;
        mode_i        = MODE_DATA;
        state_valid_i = 1'b1;
        step();
        state_valid_i      = 1'b0;
        out_if.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_if.out_ready_i = 1'b1;
            check_word($sformatf("bp_w0_%0d", i), 32'h12345678, 1'b0, 1'b0);
            step();
        end
        check_word("bp_w1", 32'hEDCBA987, 1'b1, 1'b0);
        step();
        check_idle("bp_done");
        step();

        // Reset after the first tag word is accepted.
        state_i       = st_b;
        mode_i        = MODE_FINAL;
        state_valid_i = 1'b1;
`ifdef ASCON_TAG_CHECK_EN
        expected_tag_i = 128'h0000000000000001_2222222222222222;
`endif
        step();
        state_valid_i = 1'b0;
        check_word("rm_w0", 32'h00000000, 1'b0, 1'b1);
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check_idle("rm_rst");
        check("rm_state", 128'(state_o.x0 | state_o.x1 | state_o.x2 | state_o.x3 | state_o.x4), 128'd0);
        check("rm_data",  128'(out_if.out_data_o), 128'd0);
        step();
        check_idle("rm_after");

        // New mode 01 capture after reset.
        state_i.x0    = 64'hAAAAAAAA55555555;
        data_i        = 64'h0F0F0F0FF0F0F0F0;
        mode_i        = MODE_DATA;
        state_valid_i = 1'b1;
        step();
        state_valid_i = 1'b0;
        check_word("pr_w0", 32'hA5A5A5A5, 1'b0, 1'b0);
        step();
        check_word("pr_w1", 32'hA5A5A5A5, 1'b1, 1'b0);
        step();
        check_idle("pr_done");

`ifdef ASCON_TAG_CHECK_EN
        // One-bit mismatch on the expected tag: tag_ok_o stays 0.
        step();
        state_i        = st_b;
        mode_i         = MODE_FINAL;
        expected_tag_i = 128'h0000000000000000_2222222222222223;
        state_valid_i  = 1'b1;
        step();
        state_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mm_tag_ok_send", 128'(tag_ok_o), 128'd0);
            step();
        end
        check_idle("mm_done");
        check("mm_tag_ok", 128'(tag_ok_o), 128'd0);
        step();
        check("mm_tag_ok2", 128'(tag_ok_o), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
